// File: rtl/cond_exec_stage_pkg.sv
// Shared types for the conditional execute stage: condition codes,
// NZCV bit positions, reset flag value and the E-register bundle.
package cond_exec_stage_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000,
      NE = 4'b0001,
      CS = 4'b0010,
      CC = 4'b0011,
      MI = 4'b0100,
      PL = 4'b0101,
      VS = 4'b0110,
      VC = 4'b0111,
      HI = 4'b1000,
      LS = 4'b1001,
      GE = 4'b1010,
      LT = 4'b1011,
      GT = 4'b1100,
      LE = 4'b1101,
      AL = 4'b1110,
      NV = 4'b1111
   } cond_e;

   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;

   localparam logic [3:0] FLAG_RST_DEF = 4'b0000;

   typedef struct packed {
      logic       valid;
      logic       pcs;
      logic       reg_w;
      logic       mem_w;
      logic       memto_reg;
      logic       branch;
      logic [1:0] flag_w;
      logic [3:0] alu_ctrl;
      logic [3:0] cond;
   } e_reg_t;

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// Combinational condition evaluator.
// Ports: cond (instr[31:28]), flags (NZCV) -> condEx.
module cond_check
   import cond_exec_stage_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       condEx
);

   logic  n, z, c, v;
   cond_e cc;

   assign n  = flags[N_BIT];
   assign z  = flags[Z_BIT];
   assign c  = flags[C_BIT];
   assign v  = flags[V_BIT];
   assign cc = cond_e'(cond);

   always_comb begin
      condEx = 1'b0;
      unique case (cc)
         EQ: condEx = z;
         NE: condEx = ~z;
         CS: condEx = c;
         CC: condEx = ~c;
         MI: condEx = n;
         PL: condEx = ~n;
         VS: condEx = v;
         VC: condEx = ~v;
         HI: condEx = c & ~z;
         LS: condEx = ~c | z;
         GE: condEx = (n == v);
         LT: condEx = (n != v);
         GT: condEx = ~z & (n == v);
         LE: condEx = z | (n != v);
         AL: condEx = 1'b1;
         NV: condEx = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage pipeline register with condition gating and NZCV flags.
// Ports: clk/rst, stallE/flushE, D-stage controls in, aluFlags in,
// registered E controls, condition-gated controls and flags out.
module cond_exec_stage
   import cond_exec_stage_pkg::*;
#(
   parameter logic [3:0] FLAG_RST = FLAG_RST_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stallE,
   input  logic       flushE,
   input  logic       validD,
   input  logic       pcsD,
   input  logic       regWD,
   input  logic       memWD,
   input  logic       memtoRegD,
   input  logic       branchD,
   input  logic [1:0] flagWD,
   input  logic [3:0] aluControlD,
   input  logic [3:0] condD,
   input  logic [3:0] aluFlags,
   output logic [3:0] aluControlE,
   output logic       memtoRegE,
   output logic       validE,
   output logic       condExE,
   output logic       pcSrcE,
   output logic       regWriteE,
   output logic       memWriteE,
   output logic       branchTakenE,
   output logic [3:0] flags
);

   e_reg_t     e_q, e_d;
   logic [3:0] flags_q, flags_d;
   logic       cond_ok;

   cond_check u_cond_check (
      .cond   (e_q.cond),
      .flags  (flags_q),
      .condEx (cond_ok)
   );

   assign condExE      = e_q.valid & cond_ok;
   assign pcSrcE       = condExE & e_q.pcs;
   assign regWriteE    = condExE & e_q.reg_w;
   assign memWriteE    = condExE & e_q.mem_w;
   assign branchTakenE = condExE & e_q.branch;

   assign aluControlE  = e_q.alu_ctrl;
   assign memtoRegE    = e_q.memto_reg;
   assign validE       = e_q.valid;
   assign flags        = flags_q;

   // A taken PC write kills whatever is entering E this edge.
   always_comb begin
      e_d = e_q;
      if (flushE | pcSrcE) begin
         e_d = '0;
      end else if (!stallE) begin
         e_d.valid     = validD;
         e_d.pcs       = pcsD;
         e_d.reg_w     = regWD;
         e_d.mem_w     = memWD;
         e_d.memto_reg = memtoRegD;
         e_d.branch    = branchD;
         e_d.flag_w    = flagWD;
         e_d.alu_ctrl  = aluControlD;
         e_d.cond      = condD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) e_q <= '0;
      else     e_q <= e_d;
   end

   // The E instruction commits its flags even when it is flushing.
   always_comb begin
      flags_d = flags_q;
      if (!stallE && condExE) begin
         if (e_q.flag_w[1]) begin
            flags_d[N_BIT] = aluFlags[N_BIT];
            flags_d[Z_BIT] = aluFlags[Z_BIT];
         end
         if (e_q.flag_w[0]) begin
            flags_d[C_BIT] = aluFlags[C_BIT];
            flags_d[V_BIT] = aluFlags[V_BIT];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) flags_q <= FLAG_RST;
      else     flags_q <= flags_d;
   end

endmodule

// File: doc/cond_exec_stage.md
COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

Interface
REQ-001 SHALL have parameter FLAG_RST, default 4'b0000, NZCV value loaded into the flag register on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports stallE, flushE  input  1 each  hold / bubble request for the E register.
REQ-005 SHALL have ports validD, pcsD, regWD, memWD, memtoRegD, branchD  input  1 each  decoder controls for the instruction in D.
REQ-006 SHALL have ports flagWD  input  2 ([1]=N,Z; [1:0] split, [0]=C,V); aluControlD  input  4; condD  input  4 (instr[31:28]).
REQ-007 SHALL have port aluFlags  input  4  NZCV from the ALU for the instruction in E ([3]=N, [2]=Z, [1]=C, [0]=V).
REQ-008 SHALL have outputs aluControlE  output  4; memtoRegE, validE  output  1 each  registered copies of the D inputs.
REQ-009 SHALL have outputs condExE, pcSrcE, regWriteE, memWriteE, branchTakenE  output  1 each  condition-gated controls.
REQ-010 SHALL have output flags  output  4  current NZCV register.

Function
REQ-011 E register SHALL update with priority rst > (flushE or pcSrcE) > stallE > load-from-D.
REQ-012 Flush (flushE=1 or pcSrcE=1 at the edge) SHALL clear all E fields, validE=0, even if stallE=1.
REQ-013 Stall SHALL hold every E field unchanged; load SHALL capture all D inputs, one-cycle latency D->E.
REQ-014 condExE SHALL be validE AND cond_check(condE, flags), combinational, zero latency from E state.
REQ-015 cond_check SHALL be: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 treated as 1.
REQ-016 pcSrcE, regWriteE, memWriteE, branchTakenE SHALL each equal condExE AND the matching E field (pcsE, regWE, memWE, branchE).
REQ-017 Flags SHALL update only at an edge with rst=0, stallE=0, condExE=1: flagWE[1] loads N,Z from aluFlags[3:2]; flagWE[0] loads C,V from aluFlags[1:0]; other bits hold.
REQ-018 Failed condition or validE=0 SHALL leave flags unchanged and force all gated outputs to 0.
REQ-019 Simultaneous flush and flag update SHALL both take effect: the E instruction completes its flag write, the incoming one is dropped.
REQ-020 A taken pcSrcE SHALL self-flush the next E slot without external flushE.
REQ-021 A stalled E instruction SHALL re-evaluate its condition against unchanged flags every stalled cycle.

Reset
REQ-022 At an edge with rst=1, all E fields SHALL be 0, validE=0, flags=FLAG_RST; all gated outputs 0 in the following cycle.
REQ-023 rst mid-stall or mid-flush SHALL override both; no flag write SHALL occur on a reset edge.

Structure
REQ-024 Shared package SHALL hold the 4-bit condition enum (EQ..AL, 1111), NZCV bit-index constants and FLAG_RST default.
REQ-025 Condition evaluation SHALL be one combinational sub-module named cond_check (inputs cond, flags; output condEx).
REQ-026 Flag register and E register SHALL be separate always-blocks in cond_exec_stage.

Verification
REQ-027 Reset: rst=1 one cycle with all D inputs 1 -> validE=0, flags=4'b0000, pcSrcE=regWriteE=memWriteE=0.
REQ-028 Flag write: load condD=AL, flagWD=2'b11, regWD=1, aluFlags=4'b0100 -> regWriteE=1, next cycle flags=4'b0100; then condD=EQ, memWD=1 -> memWriteE=1; condD=NE -> memWriteE=0.
REQ-029 Partial write: flags=4'b1111, condD=AL, flagWD=2'b10, aluFlags=4'b0000 -> flags=4'b0011.
REQ-030 Branch self-flush: condD=AL, pcsD=1, branchD=1 -> pcSrcE=branchTakenE=1 for one cycle, next cycle validE=0 regardless of D.
REQ-031 Stall: flags=4'b0000, condD=AL, flagWD=2'b11, aluFlags=4'b1000, stallE=1 for 3 cycles -> flags stay 4'b0000, E fields held; release -> flags=4'b1000 after one edge.
REQ-032 Signed conditions: flags N=1,V=0 with GE -> condExE=0, LT -> 1; flags Z=1 with GT -> 0, LE -> 1; flushE+stallE together -> validE=0.
